// File: rtl/vga_scanout_if.sv
// ----------------------------------------------------------------------------
// vga_scanout_if
// Bundles the framebuffer read port and the VGA DAC pins of vga_scanout.
//
//   master (scanout side)
//     fb_address   out  framebuffer read address
//     fb_q         in   framebuffer read data, one clock after fb_address
//     vga_r/g/b    out  8-bit colour per channel
//     vga_hs       out  hsync, active low
//     vga_vs       out  vsync, active low
//     vga_blank_n  out  high in the visible region
//     vga_sync_n   out  composite sync, held low
//     frame_start  out  one-clock pulse at the start of vertical blank
//     in_vblank    out  high during vertical blank
//   slave (RAM / board side): the same signals with directions reversed
// ----------------------------------------------------------------------------
interface vga_scanout_if #(
    parameter int COLOR_DEPTH = 9,
    parameter int ADDR_WIDTH  = 15
) ();
    logic [ADDR_WIDTH-1:0]  fb_address;
    logic [COLOR_DEPTH-1:0] fb_q;
    logic [7:0]             vga_r;
    logic [7:0]             vga_g;
    logic [7:0]             vga_b;
    logic                   vga_hs;
    logic                   vga_vs;
    logic                   vga_blank_n;
    logic                   vga_sync_n;
    logic                   frame_start;
    logic                   in_vblank;

    modport master (
        output fb_address,
        input  fb_q,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output vga_blank_n,
        output vga_sync_n,
        output frame_start,
        output in_vblank
    );

    modport slave (
        input  fb_address,
        output fb_q,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  vga_blank_n,
        input  vga_sync_n,
        input  frame_start,
        input  in_vblank
    );
endinterface

// File: rtl/vga_scanout.sv
// ----------------------------------------------------------------------------
// vga_scanout
// Reads the 160x120 framebuffer and drives 640x480@60 VGA, each framebuffer
// pixel replicated 4x4. The reader is free running: it never stalls and has
// no handshake with the RAM, which has a fixed one-clock read latency.
//
// Ports
//   clock    in  25 MHz pixel clock
//   resetn   in  asynchronous, active-low reset; scan restarts at (0,0)
//   bus      vga_scanout_if.master: framebuffer read port, VGA pins,
//            frame_start / in_vblank for the draw-engine scheduler
//
// Pipeline (stage 0 = counter values)
//   S1  fb_address and visible/hsync/vsync flags registered
//   S2  RAM returns fb_q; flags delayed once more
//   S3  colour and sync/blank output registers load together
// All pins derived from counter position (h,v) therefore appear exactly three
// clocks later, so colour, sync and blank stay mutually aligned.
// frame_start and in_vblank are taken straight from the counters (undelayed).
// ----------------------------------------------------------------------------
module vga_scanout #(
    parameter int COLOR_DEPTH = 9,
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic          clock,
    input  logic          resetn,
    vga_scanout_if.master bus
);

    // ------------------------------------------------------------------------
    // 640x480@60 timing, counts are inclusive
    // ------------------------------------------------------------------------
    localparam logic [9:0] H_VISIBLE    = 10'(FB_WIDTH * 4);   // 640
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'(FB_HEIGHT * 4);  // 480
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam int N_CHAN = 3;                 // R, G, B
    localparam int CH_W   = COLOR_DEPTH / N_CHAN;

    // Active-high region flags carried down the pipeline alongside the pixel.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } scan_flags_t;

    // ------------------------------------------------------------------------
    // Stage 0: raster counters
    // ------------------------------------------------------------------------
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Region decode at stage 0.
    scan_flags_t w_flags_s0;

    always_comb begin
        w_flags_s0         = '0;
        w_flags_s0.visible = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);
        w_flags_s0.hsync   = (r_h_cnt >= H_SYNC_START) && (r_h_cnt <= H_SYNC_END);
        w_flags_s0.vsync   = (r_v_cnt >= V_SYNC_START) && (r_v_cnt <= V_SYNC_END);
    end

    // Framebuffer address: row*160 + col with row = v/4, col = h/4.
    // The x160 multiply is (row<<7) + (row<<5). Inside the visible window row
    // is at most 119 and col at most 159, so the result never exceeds 19199.
    logic [6:0]            w_fb_row;
    logic [7:0]            w_fb_col;
    logic [ADDR_WIDTH-1:0] w_row_ext;
    logic [ADDR_WIDTH-1:0] w_fb_addr;

    assign w_fb_row  = r_v_cnt[8:2];
    assign w_fb_col  = r_h_cnt[9:2];
    assign w_row_ext = ADDR_WIDTH'(w_fb_row);
    assign w_fb_addr = (w_row_ext << 7) + (w_row_ext << 5) + ADDR_WIDTH'(w_fb_col);

    // ------------------------------------------------------------------------
    // Stage 1: registered read address and flags
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_fb_address;
    scan_flags_t           r_flags_s1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fb_address <= '0;
            r_flags_s1   <= '0;
        end else begin
            // Blanked positions read address 0 so the bus stays quiet.
            r_fb_address <= w_flags_s0.visible ? w_fb_addr : '0;
            r_flags_s1   <= w_flags_s0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: RAM latency; flags wait for fb_q
    // ------------------------------------------------------------------------
    scan_flags_t r_flags_s2;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_flags_s2 <= '0;
        end else begin
            r_flags_s2 <= r_flags_s1;
        end
    end

    // Colour expansion, one 3-bit channel to 8 bits: {c, c, c[2:1]}.
    // Channel 0 is blue (fb_q[2:0]), 1 green, 2 red (fb_q[8:6]).
    logic [7:0] w_chan_expanded [N_CHAN];

    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
        logic [CH_W-1:0] w_c;
        assign w_c                 = bus.fb_q[gi*CH_W +: CH_W];
        assign w_chan_expanded[gi] = {w_c, w_c, w_c[CH_W-1:1]};
    end

    // ------------------------------------------------------------------------
    // Stage 3: output registers
    // ------------------------------------------------------------------------
    logic [7:0] r_vga_r;
    logic [7:0] r_vga_g;
    logic [7:0] r_vga_b;
    logic       r_vga_hs;
    logic       r_vga_vs;
    logic       r_vga_blank_n;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_vga_blank_n <= 1'b0;
        end else begin
            // Outside the visible window the DAC must see black whatever the
            // RAM returns (it is reading address 0 then).
            r_vga_r       <= r_flags_s2.visible ? w_chan_expanded[2] : 8'd0;
            r_vga_g       <= r_flags_s2.visible ? w_chan_expanded[1] : 8'd0;
            r_vga_b       <= r_flags_s2.visible ? w_chan_expanded[0] : 8'd0;
            r_vga_hs      <= ~r_flags_s2.hsync;
            r_vga_vs      <= ~r_flags_s2.vsync;
            r_vga_blank_n <= r_flags_s2.visible;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.fb_address  = r_fb_address;
    assign bus.vga_r       = r_vga_r;
    assign bus.vga_g       = r_vga_g;
    assign bus.vga_b       = r_vga_b;
    assign bus.vga_hs      = r_vga_hs;
    assign bus.vga_vs      = r_vga_vs;
    assign bus.vga_blank_n = r_vga_blank_n;
    assign bus.vga_sync_n  = 1'b0;

    // Scheduler hints come straight off the counters so the background
    // engine gets the whole blanking interval.
    assign bus.frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == V_VISIBLE);
    assign bus.in_vblank   = (r_v_cnt >= V_VISIBLE);

endmodule

// File: tb/tb_vga_scanout.sv
// ----------------------------------------------------------------------------
// tb_vga_scanout
// Scoreboard bench for vga_scanout. A reference model computes, for every
// raster position since reset, the expected read address, pin values and
// scheduler flags straight from the raster rules, queueing each with the
// cycle it is due. A separate monitor pops and compares every cycle.
// Framebuffer contents are random; long idle stretches are skipped by
// moving the line counter, and the model follows the same jump.
// ----------------------------------------------------------------------------
module tb_vga_scanout;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #10 clock = ~clock;

    vga_scanout_if bus ();

    vga_scanout dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Framebuffer RAM with one-clock read latency.
    logic [8:0] mem [0:32767];

    always @(posedge clock) bus.fb_q <= mem[bus.fb_address];

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    typedef struct {
        longint     due;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank_n;
    } pins_t;

    typedef struct {
        longint      due;
        logic [14:0] addr;
    } addr_t;

    typedef struct {
        longint due;
        logic   fs;
        logic   vb;
    } flag_t;

    pins_t pins_q [$];
    addr_t addr_q [$];
    flag_t flag_q [$];

    int     checks  = 0;
    int     errors  = 0;
    longint cyc     = 0;
    longint c0      = 0;      // cycle in which the model's position 0 occurred
    bit     running = 1'b0;
    int     fs_seen = 0;
    int     fs_exp  = 0;
    logic [9:0] jump_v;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // 3-bit to 8-bit intensity, rounded to nearest of c*255/7.
    function automatic logic [7:0] intensity(input logic [2:0] c);
        return 8'((int'(c) * 255 + 3) / 7);
    endfunction

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    initial begin
        longint p;
        int     h, v, a;
        bit     vis;
        logic [8:0] w;
        pins_t  pe;
        addr_t  ae;
        flag_t  fe;
        forever begin
            @(posedge clock);
            #4;
            if (!resetn) begin
                running = 1'b0;
            end else begin
                if (!running) begin
                    running = 1'b1;
                    c0      = cyc;
                    // Pipeline still holds reset state for three clocks.
                    for (int k = 0; k < 3; k++) begin
                        pe = '{due: cyc + k, r: 8'd0, g: 8'd0, b: 8'd0,
                               hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
                        pins_q.push_back(pe);
                    end
                    ae = '{due: cyc, addr: 15'd0};
                    addr_q.push_back(ae);
                end
                p   = (cyc - c0) % 420000;
                h   = int'(p % 800);
                v   = int'(p / 800);
                vis = (h < 640) && (v < 480);
                a   = vis ? (v / 4) * 160 + (h / 4) : 0;
                w   = mem[a];

                ae = '{due: cyc + 1, addr: 15'(a)};
                addr_q.push_back(ae);

                pe.due     = cyc + 3;
                pe.r       = vis ? intensity(w[8:6]) : 8'd0;
                pe.g       = vis ? intensity(w[5:3]) : 8'd0;
                pe.b       = vis ? intensity(w[2:0]) : 8'd0;
                pe.hs      = !(h >= 656 && h < 752);
                pe.vs      = !(v >= 490 && v < 492);
                pe.blank_n = vis;
                pins_q.push_back(pe);

                fe = '{due: cyc, fs: (h == 0 && v == 480), vb: (v >= 480)};
                if (fe.fs) fs_exp++;
                flag_q.push_back(fe);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        pins_t pe;
        addr_t ae;
        flag_t fe;
        forever begin
            @(posedge clock);
            #6;
            if (resetn) begin
                if (bus.frame_start) fs_seen++;
                while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                    ae = addr_q.pop_front();
                    chk("fb_address", longint'(bus.fb_address), longint'(ae.addr));
                end
                while (pins_q.size() > 0 && pins_q[0].due <= cyc) begin
                    pe = pins_q.pop_front();
                    checks++;
                    if (bus.vga_r !== pe.r || bus.vga_g !== pe.g || bus.vga_b !== pe.b ||
                        bus.vga_hs !== pe.hs || bus.vga_vs !== pe.vs ||
                        bus.vga_blank_n !== pe.blank_n || bus.vga_sync_n !== 1'b0) begin
                        errors++;
                        $display("FAIL pins cyc=%0d got rgb=%h/%h/%h hs=%b vs=%b blank_n=%b sync_n=%b exp rgb=%h/%h/%h hs=%b vs=%b blank_n=%b sync_n=0",
                                 cyc, bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs,
                                 bus.vga_blank_n, bus.vga_sync_n, pe.r, pe.g, pe.b, pe.hs,
                                 pe.vs, pe.blank_n);
                    end
                end
                while (flag_q.size() > 0 && flag_q[0].due <= cyc) begin
                    fe = flag_q.pop_front();
                    checks++;
                    if (bus.frame_start !== fe.fs || bus.in_vblank !== fe.vb) begin
                        errors++;
                        $display("FAIL flags cyc=%0d got frame_start=%b in_vblank=%b exp frame_start=%b in_vblank=%b",
                                 cyc, bus.frame_start, bus.in_vblank, fe.fs, fe.vb);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    // Assert reset mid-cycle, verify every pin clears at once, then release.
    task automatic do_reset(input int hold);
        @(posedge clock);
        #12;
        resetn = 1'b0;
        #1;
        chk("rst_fb_address",  longint'(bus.fb_address),  0);
        chk("rst_vga_r",       longint'(bus.vga_r),       0);
        chk("rst_vga_g",       longint'(bus.vga_g),       0);
        chk("rst_vga_b",       longint'(bus.vga_b),       0);
        chk("rst_vga_hs",      longint'(bus.vga_hs),      1);
        chk("rst_vga_vs",      longint'(bus.vga_vs),      1);
        chk("rst_vga_blank_n", longint'(bus.vga_blank_n), 0);
        chk("rst_frame_start", longint'(bus.frame_start), 0);
        chk("rst_in_vblank",   longint'(bus.in_vblank),   0);
        pins_q.delete();
        addr_q.delete();
        flag_q.delete();
        repeat (hold) @(posedge clock);
        #2;
        resetn = 1'b1;
    endtask

    // Move the scan to line v at the current column; the model follows.
    task automatic jump_to_line(input int v);
        int h;
        @(posedge clock);
        #1;
        h      = int'(((cyc - c0) % 420000) % 800);
        jump_v = 10'(v);
        force dut.r_v_cnt = jump_v;
        #1;
        release dut.r_v_cnt;
        c0 = cyc - (longint'(v) * 800 + h);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 9'($urandom);
        // A solid patch in the top-left corner: expands to B6/49/FF.
        for (int i = 0; i < 40; i++) mem[i] = 9'b101_010_111;

        do_reset(3);
        repeat (2500) @(posedge clock);

        // Reset at a random point mid-line.
        repeat ($urandom_range(100, 700)) @(posedge clock);
        do_reset(2);
        repeat (2000) @(posedge clock);

        // Bottom of the visible area through frame_start, vblank and vsync.
        jump_to_line(477);
        repeat (16 * 800) @(posedge clock);

        // Reset while vsync is on the pins.
        jump_to_line(490);
        repeat ($urandom_range(50, 300)) @(posedge clock);
        do_reset(2);
        repeat (2000) @(posedge clock);

        // Clean vsync after the reset, then the frame wrap.
        jump_to_line(488);
        repeat (5 * 800) @(posedge clock);
        jump_to_line(522);
        repeat (4 * 800) @(posedge clock);
        repeat (5) @(posedge clock);
        #8;

        chk("frame_start_count", longint'(fs_seen), longint'(fs_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
